mdu_seq_ctrl: RTL and testbench

//  Sequencer for an iterative RV32M multiply/divide unit attached to the EX stage.
//  It detects an M-extension instruction in EX and latches its forwarded operands.
//  It then runs a 32-step shift-add / restoring-divide loop and holds the pipeline

---
 rtl/mdu_seq_ctrl_pkg.sv | 32 +++
 rtl/mdu_seq_ctrl_iter.sv | 56 +++++
 rtl/mdu_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_mdu_seq_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_seq_ctrl_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: FSM states,
// M-extension FUNCT3 codes and operand-signedness helpers.
package mdu_seq_ctrl_pkg;

    localparam int unsigned MDU_XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_t;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } mdu_funct3_t;

    function automatic logic op_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic op_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/mdu_seq_ctrl_iter.sv
// Iterative datapath: 2*XLEN accumulator doing one shift-add (multiply) or one
// restoring shift-subtract (divide) step per cycle on unsigned magnitudes.
module mdu_iter_core #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_step,
    input  logic              i_is_div,
    input  logic [XLEN-1:0]   i_opnd,
    input  logic [XLEN-1:0]   i_seed,
    output logic [2*XLEN-1:0] o_acc
);

    logic [XLEN-1:0]   r_opnd;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN:0]     w_add;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_sub;
    logic [2*XLEN-1:0] w_next;

    // Multiply: acc = {partial, multiplier}, shifted right with the carry.
    // Divide:   acc = {remainder, dividend/quotient}, shifted left; quotient bits enter at LSB.
    always_comb begin
        w_add    = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opnd};
        w_rem_sh = r_acc[2*XLEN-1:XLEN-1];
        w_sub    = w_rem_sh - {1'b0, r_opnd};
        w_next   = r_acc;
        if (i_is_div) begin
            if (w_rem_sh >= {1'b0, r_opnd})
                w_next = {w_sub[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
            else
                w_next = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        end else if (r_acc[0]) begin
            w_next = {w_add, r_acc[XLEN-1:1]};
        end else begin
            w_next = {1'b0, r_acc[2*XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opnd <= '0;
            r_acc  <= '0;
        end else if (i_load) begin
            r_opnd <= i_opnd;
            r_acc  <= {{XLEN{1'b0}}, i_seed};
        end else if (i_step) begin
            r_acc  <= w_next;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/mdu_seq_ctrl.sv
// EX-stage sequencer for the RV32M unit: FSM, iteration counter, special-case
// detection, sign fix-up and pipeline stall generation around mdu_iter_core.
module mdu_seq_ctrl
    import mdu_seq_ctrl_pkg::*;
#(
    parameter int unsigned XLEN  = MDU_XLEN,
    parameter int unsigned ITER  = XLEN,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MulDiv_EX,
    input  logic [2:0]      FUNCT3_EX,
    input  logic [XLEN-1:0] SRC1_EX,
    input  logic [XLEN-1:0] SRC2_EX,
    input  logic            flush_EX,
    output logic            stall_MDU,
    output logic            MDU_valid_EX,
    output logic [XLEN-1:0] MDU_OUT_EX,
    output logic            MDU_busy
);

    mdu_state_t        r_state;
    mdu_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_count;
    logic [2:0]        r_funct3;
    logic              r_neg;
    logic              r_special;
    logic [XLEN-1:0]   r_spec_val;

    logic              w_start;
    logic              w_is_div;
    logic              w_a_neg;
    logic              w_b_neg;
    logic              w_neg;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic              w_last;
    logic              w_load;
    logic              w_step;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic [XLEN-1:0]   w_spec_val;
    logic [XLEN-1:0]   w_opnd;
    logic [XLEN-1:0]   w_seed;
    logic [XLEN-1:0]   w_res_raw;
    logic [XLEN-1:0]   w_res;
    logic [2*XLEN-1:0] w_acc;
    logic [2*XLEN-1:0] w_prod;

    // Operand decode, evaluated on the live EX inputs; only latched in IDLE.
    always_comb begin
        w_is_div   = FUNCT3_EX[2];
        w_a_neg    = op_signed_a(FUNCT3_EX) & SRC1_EX[XLEN-1];
        w_b_neg    = op_signed_b(FUNCT3_EX) & SRC2_EX[XLEN-1];
        w_mag_a    = w_a_neg ? (~SRC1_EX + 1'b1) : SRC1_EX;
        w_mag_b    = w_b_neg ? (~SRC2_EX + 1'b1) : SRC2_EX;
        w_neg      = w_a_neg ^ (w_b_neg & (FUNCT3_EX != F3_REM));
        w_div0     = w_is_div & (SRC2_EX == '0);
        w_ovf      = ((FUNCT3_EX == F3_DIV) || (FUNCT3_EX == F3_REM))
                   & (SRC1_EX == {1'b1, {(XLEN-1){1'b0}}}) & (SRC2_EX == '1);
        w_special  = w_div0 | w_ovf;
        if (w_div0)
            w_spec_val = FUNCT3_EX[1] ? SRC1_EX : '1;
        else
            w_spec_val = FUNCT3_EX[1] ? '0 : SRC1_EX;
        w_start    = (r_state == ST_IDLE) & MulDiv_EX & ~flush_EX;
        w_load     = w_start & ~w_special;
        w_step     = (r_state == ST_RUN);
        w_opnd     = w_is_div ? w_mag_b : w_mag_a;
        w_seed     = w_is_div ? w_mag_a : w_mag_b;
        w_last     = (r_count == CNT_W'(ITER - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush_EX) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (MulDiv_EX) w_state_nxt = w_special ? ST_DONE : ST_RUN;
                ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_funct3   <= '0;
            r_neg      <= 1'b0;
            r_special  <= 1'b0;
            r_spec_val <= '0;
        end else if (w_start) begin
            r_count    <= '0;
            r_funct3   <= FUNCT3_EX;
            r_neg      <= w_neg;
            r_special  <= w_special;
            r_spec_val <= w_spec_val;
        end else if (r_state == ST_RUN) begin
            r_count    <= r_count + 1'b1;
        end
    end

    mdu_iter_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk      (clk),
        .rst      (reset),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_is_div (r_funct3[2]),
        .i_opnd   (w_opnd),
        .i_seed   (w_seed),
        .o_acc    (w_acc)
    );

    // Output process; reset also masks stall so the pipeline is released at once.
    always_comb begin
        w_prod    = r_neg ? (~w_acc + 1'b1) : w_acc;
        w_res_raw = r_funct3[1] ? w_acc[2*XLEN-1:XLEN] : w_acc[XLEN-1:0];
        if (r_special)
            w_res = r_spec_val;
        else if (r_funct3[2])
            w_res = r_neg ? (~w_res_raw + 1'b1) : w_res_raw;
        else if (r_funct3[1:0] == 2'b00)
            w_res = w_prod[XLEN-1:0];
        else
            w_res = w_prod[2*XLEN-1:XLEN];
        MDU_busy     = (r_state != ST_IDLE);
        MDU_valid_EX = (r_state == ST_DONE) & MulDiv_EX & ~flush_EX & ~reset;
        stall_MDU    = MulDiv_EX & (r_state != ST_DONE) & ~flush_EX & ~reset;
        MDU_OUT_EX   = MDU_valid_EX ? w_res : '0;
    end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Scoreboard bench for mdu_seq_ctrl: directed ops push expected results,
// a negedge monitor pops and compares whenever MDU_valid_EX is seen.
module tb_mdu_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        MulDiv_EX;
    logic [2:0]  FUNCT3_EX;
    logic [31:0] SRC1_EX;
    logic [31:0] SRC2_EX;
    logic        flush_EX;
    logic        stall_MDU;
    logic        MDU_valid_EX;
    logic [31:0] MDU_OUT_EX;
    logic        MDU_busy;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    logic [31:0] sb_exp[$];
    string       sb_name[$];

    mdu_seq_ctrl #(
        .XLEN  (32),
        .ITER  (32),
        .CNT_W (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .MulDiv_EX    (MulDiv_EX),
        .FUNCT3_EX    (FUNCT3_EX),
        .SRC1_EX      (SRC1_EX),
        .SRC2_EX      (SRC2_EX),
        .flush_EX     (flush_EX),
        .stall_MDU    (stall_MDU),
        .MDU_valid_EX (MDU_valid_EX),
        .MDU_OUT_EX   (MDU_OUT_EX),
        .MDU_busy     (MDU_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every valid result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && MDU_valid_EX) begin
            if (sb_exp.size() == 0) begin
                check(1'b0, "unexpected_valid", MDU_OUT_EX, 32'h0);
            end else begin
                logic [31:0] e;
                string       nm;
                e  = sb_exp.pop_front();
                nm = sb_name.pop_front();
                check(MDU_OUT_EX === e, nm, MDU_OUT_EX, e);
            end
        end
    end

    // Issue one op; checks stall-cycle count and the cycle at which valid appears.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_stall, input string name,
                          input bit keep, input bit scramble);
        int  stalls;
        int  vcyc;
        bit  got;
        @(posedge clk); #1;
        MulDiv_EX = 1'b1;
        FUNCT3_EX = f3;
        SRC1_EX   = a;
        SRC2_EX   = b;
        sb_exp.push_back(exp);
        sb_name.push_back(name);
        stalls = 0;
        vcyc   = -1;
        got    = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (stall_MDU) stalls++;
            if (MDU_valid_EX) begin
                got  = 1'b1;
                vcyc = c;
            end
            if (scramble && c == 5) begin
                SRC1_EX = 32'hDEADBEEF;
                SRC2_EX = 32'h00000001;
            end
        end
        check(got, {name, "_valid_seen"}, 32'(got), 32'd1);
        check(vcyc == exp_stall, {name, "_latency"}, 32'(vcyc), 32'(exp_stall));
        check(stalls == exp_stall, {name, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
        if (!keep) begin
            @(posedge clk); #1;
            MulDiv_EX = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got 0 expected 1");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        MulDiv_EX = 1'b0;
        FUNCT3_EX = 3'b000;
        SRC1_EX   = '0;
        SRC2_EX   = '0;
        flush_EX  = 1'b0;
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        check(MDU_busy == 1'b0,     "rst_busy",  32'(MDU_busy),     32'd0);
        check(MDU_valid_EX == 1'b0, "rst_valid", 32'(MDU_valid_EX), 32'd0);
        check(stall_MDU == 1'b0,    "rst_stall", 32'(stall_MDU),    32'd0);
        check(MDU_OUT_EX == 32'h0,  "rst_out",   MDU_OUT_EX,        32'h0);
        @(posedge clk); #1 reset = 1'b0;

        run_op(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul_7_m3",     0, 0);
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu_max",    0, 0);
        run_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh_min",     0, 0);
        run_op(3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, "mulhsu_m1_2",  0, 0);
        run_op(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div_m7_2",     0, 0);
        run_op(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "rem_m7_2",     0, 0);
        run_op(3'b101, 32'd100,      32'd7,        32'd14,       33, "divu_100_7",   0, 0);
        run_op(3'b111, 32'd100,      32'd7,        32'd2,        33, "remu_100_7",   0, 0);
        run_op(3'b101, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, 33, "divu_max_16",  0, 0);
        run_op(3'b100, 32'h00001234, 32'd0,        32'hFFFFFFFF, 1,  "div_by0",      0, 0);
        run_op(3'b111, 32'd5,        32'd0,        32'd5,        1,  "remu_by0",     0, 0);
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf",      0, 0);
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  "rem_ovf",      0, 0);
        run_op(3'b101, 32'd100,      32'd7,        32'd14,       33, "divu_scram",   0, 1);
        run_op(3'b000, 32'd12345,    32'd1000,     32'h00BC5EA8, 33, "b2b_mul",      1, 0);
        run_op(3'b101, 32'd1000,     32'd33,       32'd30,       33, "b2b_divu",     0, 0);

        // Flush while RUN with count==10.
        @(posedge clk); #1;
        MulDiv_EX = 1'b1; FUNCT3_EX = 3'b000; SRC1_EX = 32'd3; SRC2_EX = 32'd5;
        repeat (12) @(negedge clk);
        check(MDU_busy == 1'b1, "flush_pre_busy", 32'(MDU_busy), 32'd1);
        flush_EX = 1'b1;
        #1 check(stall_MDU == 1'b0, "flush_stall", 32'(stall_MDU), 32'd0);
        @(posedge clk); #1;
        flush_EX = 1'b0; MulDiv_EX = 1'b0;
        @(negedge clk);
        check(MDU_busy == 1'b0,     "flush_idle",  32'(MDU_busy),     32'd0);
        check(MDU_valid_EX == 1'b0, "flush_valid", 32'(MDU_valid_EX), 32'd0);
        repeat (40) @(negedge clk);

        // Async reset while RUN with count==20.
        @(posedge clk); #1;
        MulDiv_EX = 1'b1; FUNCT3_EX = 3'b101; SRC1_EX = 32'd100; SRC2_EX = 32'd7;
        repeat (22) @(negedge clk);
        check(MDU_busy == 1'b1, "arst_pre_busy", 32'(MDU_busy), 32'd1);
        reset = 1'b1;
        #1;
        check(MDU_busy == 1'b0,     "arst_busy",  32'(MDU_busy),     32'd0);
        check(MDU_valid_EX == 1'b0, "arst_valid", 32'(MDU_valid_EX), 32'd0);
        check(stall_MDU == 1'b0,    "arst_stall", 32'(stall_MDU),    32'd0);
        check(MDU_OUT_EX == 32'h0,  "arst_out",   MDU_OUT_EX,        32'h0);
        MulDiv_EX = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        repeat (40) @(negedge clk);

        run_op(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul_after_rst", 0, 0);

        repeat (5) @(negedge clk);
        check(sb_exp.size() == 0, "scoreboard_drain", 32'(sb_exp.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
